weight_row_writer: RTL and testbench

WEIGHT_ROW_WRITER -- requirements
Module: weight_row_writer

---
 rtl/weight_row_writer_if.sv | 27 ++
 rtl/weight_row_writer.sv | 102 ++++++++++
 tb/tb_weight_row_writer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/weight_row_writer_if.sv
// Bus bundle for weight_row_writer: load handshake, status flags and row read port.
// Handshake: a word moves on a rising edge where in_valid and in_ready are both 1.
interface weight_row_writer_if #(
  parameter int N         = 8,
  parameter int n         = 16,
  parameter int addrwidth = 2
);
  logic                 start;
  logic                 in_valid;
  logic [n-1:0]         in_data;
  logic                 in_ready;
  logic                 busy;
  logic                 done;
  logic [addrwidth:0]   addr;
  logic [N*n-1:0]       W;
  logic [1:0]           dbg_state;

  modport master (
    output start, in_valid, in_data, addr,
    input  in_ready, busy, done, W, dbg_state
  );

  modport slave (
    input  start, in_valid, in_data, addr,
    output in_ready, busy, done, W, dbg_state
  );
endinterface

// File: rtl/weight_row_writer.sv
// Streams N-word rows into S row registers through a staging register; rows
// change only on the edge that accepts their last word, and are read combinationally.
module weight_row_writer #(
   parameter int N         = 8,
   parameter int S         = 8,
   parameter int n         = 16,
   parameter int addrwidth = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   weight_row_writer_if.slave bus
);

   localparam int WCW = (N > 1) ? $clog2(N) : 1;
   localparam int RCW = (S > 1) ? $clog2(S) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]     r_state;
   logic [WCW-1:0] r_word;
   logic [RCW-1:0] r_row;
   logic [N*n-1:0] r_stage;
   logic [N*n-1:0] r_rows [S];

   logic           w_accept;
   logic           w_last_word;
   logic           w_last_row;
   logic [N*n-1:0] w_stage_next;
   logic [RCW-1:0] w_rd_idx;

   assign w_accept    = bus.in_valid && (r_state == ST_LOAD);
   assign w_last_word = (r_word == WCW'(N-1));
   assign w_last_row  = (r_row == RCW'(S-1));

   // Word k lands in slice N-1-k so the first word ends up most significant.
   always_comb begin
      w_stage_next = r_stage;
      w_stage_next[(N-1-int'(r_word))*n +: n] = bus.in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_word  <= '0;
         r_row   <= '0;
         r_stage <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_state <= ST_LOAD;
                  r_word  <= '0;
                  r_row   <= '0;
                  r_stage <= '0;
               end
            end
            ST_LOAD: begin
               if (bus.in_valid) begin
                  r_stage <= w_stage_next;
                  if (!w_last_word) begin
                     r_word <= r_word + WCW'(1);
                  end else begin
                     r_word <= '0;
                     if (w_last_row) begin
                        r_row   <= '0;
                        r_state <= ST_DONE;
                     end else begin
                        r_row <= r_row + RCW'(1);
                     end
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // The commit writes the staged row including the word arriving on this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < S; i++) r_rows[i] <= '0;
      end else if (w_accept && w_last_word) begin
         r_rows[r_row] <= w_stage_next;
      end
   end

   assign w_rd_idx = RCW'(bus.addr);

   always_comb begin
      bus.W = '0;
      if (int'(bus.addr) < S) bus.W = r_rows[w_rd_idx];
   end

   assign bus.in_ready  = (r_state == ST_LOAD);
   assign bus.busy      = (r_state == ST_LOAD);
   assign bus.done      = (r_state == ST_DONE);
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_weight_row_writer.sv
// Randomized bench for weight_row_writer against a word-queue reference model.
module tb_weight_row_writer;
  localparam int N  = 8;
  localparam int S  = 8;
  localparam int NB = 16;
  // Wider address so reads beyond the last row are reachable.
  localparam int AW = 3;
  localparam int CW = N * NB;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  weight_row_writer_if #(.N(N), .n(NB), .addrwidth(AW)) bus ();

  weight_row_writer #(.N(N), .S(S), .n(NB), .addrwidth(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [CW-1:0] ref_rows [S];
  logic [NB-1:0] pend_q [$];
  int ref_row;
  int mode;           // 0 idle, 1 loading, 2 done
  int busy_cycles;
  int done_pulses;

  task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack_row();
    logic [CW-1:0] r = '0;
    foreach (pend_q[k]) r = (r << NB) | CW'(pend_q[k]);
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_w(input logic [AW:0] a);
    if (int'(a) < S) return ref_rows[int'(a)];
    return '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < S; i++) ref_rows[i] = '0;
    pend_q.delete();
    ref_row = 0;
    mode = 0;
  endtask

  // One clock: drive after the edge, check at the falling edge, then advance the model.
  task automatic cycle(input logic v, input logic [NB-1:0] d, input logic st, input logic [AW:0] a);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.start    = st;
    bus.addr     = a;
    @(negedge clk);
    check_eq("W", bus.W, exp_w(a));
    check_eq("busy", CW'(bus.busy), CW'(mode == 1));
    check_eq("in_ready", CW'(bus.in_ready), CW'(mode == 1));
    check_eq("done", CW'(bus.done), CW'(mode == 2));
    if (bus.busy) busy_cycles++;
    if (bus.done) done_pulses++;
    case (mode)
      0: if (st) begin
           mode = 1;
           ref_row = 0;
           pend_q.delete();
         end
      1: if (v) begin
           pend_q.push_back(d);
           if (pend_q.size() == N) begin
             ref_rows[ref_row] = pack_row();
             pend_q.delete();
             ref_row++;
             if (ref_row == S) mode = 2;
           end
         end
      default: mode = 0;
    endcase
  endtask

  function automatic logic [NB-1:0] gen_word(input int sel, input int idx);
    case (sel)
      0: return ((idx / N) % 2 == 0) ? 16'h8400 : 16'h0400;
      1: return NB'(idx + 1);
      default: return NB'($urandom);
    endcase
  endfunction

  // Feeds nwords accepted words; fix_addr < 0 means random read address.
  task automatic load_words(input int sel, input int gap_max, input bit mid_start,
                            input int nwords, input int fix_addr);
    int sent = 0;
    int guard = 0;
    logic v, st, acc;
    logic [AW:0] a;
    while (sent < nwords && guard < 5000) begin
      v   = (gap_max == 0) || ($urandom_range(0, gap_max) == 0);
      st  = mid_start && ($urandom_range(0, 7) == 0);
      a   = (fix_addr < 0) ? AW'($urandom_range(0, 15)) : (AW+1)'(fix_addr);
      acc = v && (mode == 1);
      cycle(v, v ? gen_word(sel, sent) : NB'($urandom), st, a);
      if (acc) sent++;
      guard++;
    end
    if (sent != nwords) check_eq("load_timeout", CW'(sent), CW'(nwords));
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    #1;
    check_eq("rst_busy", CW'(bus.busy), '0);
    check_eq("rst_in_ready", CW'(bus.in_ready), '0);
    check_eq("rst_done", CW'(bus.done), '0);
    for (int a = 0; a < 16; a++) begin
      bus.addr = (AW+1)'(a);
      #1;
      check_eq("rst_W", bus.W, '0);
    end
    repeat (2) @(negedge clk);
    check_eq("rst_hold_busy", CW'(bus.busy), '0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic sweep_rows(input string tag);
    for (int a = 0; a < 16; a++) cycle(1'b0, '0, 1'b0, (AW+1)'(a));
  endtask

  initial begin
    logic [CW-1:0] packed_exp;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.addr = '0;
    busy_cycles = 0;
    done_pulses = 0;

    // Reset state
    apply_reset();
    sweep_rows("reset");

    // Full back-to-back load with the alternating pattern
    busy_cycles = 0;
    done_pulses = 0;
    cycle(1'b0, '0, 1'b1, '0);
    load_words(0, 0, 1'b0, N*S, -1);
    cycle(1'b1, 16'hffff, 1'b0, 4'd0);
    check_eq("W0_pattern", bus.W, {N{16'h8400}});
    cycle(1'b1, 16'hffff, 1'b0, 4'd1);
    check_eq("W1_pattern", bus.W, {N{16'h0400}});
    cycle(1'b0, '0, 1'b0, 4'd8);
    check_eq("W8_zero", bus.W, '0);
    check_eq("busy_cycles", CW'(busy_cycles), CW'(64));
    check_eq("done_pulses", CW'(done_pulses), CW'(1));

    // Packing order and atomic commit of row 0
    cycle(1'b0, '0, 1'b1, '0);
    load_words(1, 2, 1'b0, N, 0);
    cycle(1'b0, '0, 1'b0, '0);
    packed_exp = '0;
    for (int k = 1; k <= N; k++) packed_exp = (packed_exp << NB) | CW'(k);
    check_eq("W0_packed", bus.W, packed_exp);
    load_words(2, 2, 1'b0, N*S - N, -1);
    sweep_rows("packing");

    // Stalls, ignored start during load, in_valid held in DONE/IDLE
    done_pulses = 0;
    cycle(1'b1, 16'h1234, 1'b1, '0);
    load_words(2, 3, 1'b1, N*S, -1);
    for (int i = 0; i < 4; i++) cycle(1'b1, NB'($urandom), 1'b0, AW'($urandom_range(0, 15)));
    check_eq("done_pulses_stall", CW'(done_pulses), CW'(1));
    sweep_rows("stall");

    // Reset after row 3 commits, then a fresh load
    cycle(1'b0, '0, 1'b1, '0);
    load_words(2, 1, 1'b0, 4*N + 3, -1);
    apply_reset();
    sweep_rows("after_reset");
    cycle(1'b0, '0, 1'b1, '0);
    load_words(2, 1, 1'b0, N*S, -1);
    cycle(1'b0, '0, 1'b0, '0);
    sweep_rows("reload");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
